// File: rtl/rcs_serial_sub_ctrl.sv
// rcs_serial_sub_ctrl: WIDTH-bit A-B one nibble per clock on a shared 4-bit subtractor; start/op_a/op_b in, busy/done/result/borrow/zero out, sub_a/sub_b/sub_cin out to and sub_s/sub_cout back from the subtractor
module rcs_serial_sub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             zero,
  output logic [3:0]       sub_a,
  output logic [3:0]       sub_b,
  output logic             sub_cin,
  input  logic [3:0]       sub_s,
  input  logic             sub_cout
);
  localparam int NNIB = WIDTH / 4;
  localparam int IW = $clog2(NNIB);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, res_nxt;
  logic [IW-1:0] idx;
  logic carry, run, last;
  always_comb begin
    run = state == RUN;
    last = idx == IW'(NNIB - 1);
    state_nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
    sub_a = run ? a_q[{idx, 2'b00} +: 4] : 4'h0;
    sub_b = run ? b_q[{idx, 2'b00} +: 4] : 4'h0;
    sub_cin = run ? carry : 1'b0;
    res_nxt = result;
    res_nxt[{idx, 2'b00} +: 4] = sub_s;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b1;
      a_q <= '0;
      b_q <= '0;
      result <= '0;
      borrow <= 1'b0;
      zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        a_q <= op_a;
        b_q <= op_b;
        idx <= '0;
        carry <= 1'b1;
        result <= '0;
        borrow <= 1'b0;
        zero <= 1'b0;
      end else if (run) begin
        result <= res_nxt;
        carry <= sub_cout;
        idx <= last ? '0 : idx + 1'b1;
        if (last) begin
          borrow <= ~sub_cout;
          zero <= res_nxt == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rcs_serial_sub_ctrl.sv
// tb_rcs_serial_sub_ctrl: randomized and directed checks of rcs_serial_sub_ctrl against an arithmetic reference
module tb_rcs_serial_sub_ctrl;
  localparam int WIDTH = 16;
  localparam int NNIB = WIDTH / 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0, result;
  logic busy, done, borrow, zero, sub_cin, sub_cout;
  logic [3:0] sub_a, sub_b, sub_s;
  int n_cmp = 0, n_err = 0;

  rcs_serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .borrow(borrow), .zero(zero),
    .sub_a(sub_a), .sub_b(sub_b), .sub_cin(sub_cin), .sub_s(sub_s), .sub_cout(sub_cout)
  );

  always #5 clk = ~clk;

  logic [4:0] rcs_sum;
  assign rcs_sum = {1'b0, sub_a} + {1'b0, ~sub_b} + {4'b0, sub_cin};
  assign sub_s = rcs_sum[3:0];
  assign sub_cout = rcs_sum[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_cin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int k);
    longint m;
    m = (longint'(1) << (4 * k)) - 1;
    return k == 0 ? 1'b1 : ((longint'(a) & m) >= (longint'(b) & m));
  endfunction

  // Entered at the negedge after the accepting edge; leaves at the negedge after DONE.
  // With mid set, a new start with different operands is raised during RUN and held.
  task automatic do_run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit mid,
                        output logic [WIDTH-1:0] na, output logic [WIDTH-1:0] nb);
    logic [WIDTH-1:0] d;
    na = '0;
    nb = '0;
    for (int k = 0; k < NNIB; k++) begin
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("sub_a", 32'(sub_a), 32'((a >> (4 * k)) & 16'hF));
      check("sub_b", 32'(sub_b), 32'((b >> (4 * k)) & 16'hF));
      check("sub_cin", 32'(sub_cin), 32'(exp_cin(a, b, k)));
      if (mid && k == 1) begin
        na = ~a;
        nb = WIDTH'($urandom);
        start = 1'b1;
        op_a = na;
        op_b = nb;
      end
      @(negedge clk);
    end
    d = a - b;
    check("done", 32'(done), 32'd1);
    check("result", 32'(result), 32'(d));
    check("borrow", 32'(borrow), 32'(a < b));
    check("zero", 32'(zero), 32'(a == b));
    @(negedge clk);
    check("done_once", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("result_hold", 32'(result), 32'(d));
    check("idle_sub_a", 32'(sub_a), 32'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit mid);
    logic [WIDTH-1:0] na, nb, xa, xb;
    start = 1'b1;
    op_a = a;
    op_b = b;
    @(negedge clk);
    start = 1'b0;
    op_a = WIDTH'($urandom);
    op_b = WIDTH'($urandom);
    do_run(a, b, mid, na, nb);
    if (mid) begin
      @(negedge clk);
      start = 1'b0;
      check("held_start_taken", 32'(busy), 32'd1);
      do_run(na, nb, 1'b0, xa, xb);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({borrow, zero}), 32'd0);
    check("rst_sub", 32'({sub_a, sub_b, sub_cin}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'h0005, 16'h0001, 1'b0);
    run_op(16'h0005, 16'h0008, 1'b0);
    run_op(16'h1000, 16'h0001, 1'b0);
    run_op(16'hA5A5, 16'hA5A5, 1'b0);
    run_op(16'h0000, 16'hFFFF, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b0);
    run_op(16'h1234, 16'h0042, 1'b1);
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      run_op(ra, rb, $urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    start = 1'b1;
    op_a = 16'h7654;
    op_b = 16'h0123;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", 32'({borrow, zero}), 32'd0);
    check("abort_sub", 32'({sub_a, sub_b, sub_cin}), 32'd0);
    for (int i = 0; i < NNIB + 2; i++) begin
      check("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    run_op(16'h0010, 16'h0001, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
